// File: rtl/rx_pkg.sv
// rtl/rx_pkg.sv - shared state and error-code definitions for the rx frame controller
package rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HUNT,
        ST_LEN,
        ST_PAYLOAD,
        ST_CHECK,
        ST_ERR
    } rx_state_t;

    localparam logic [2:0] ERR_NONE = 3'd0;
    localparam logic [2:0] ERR_LEN  = 3'd1;
    localparam logic [2:0] ERR_CSUM = 3'd2;
    localparam logic [2:0] ERR_TMO  = 3'd3;
    localparam logic [2:0] ERR_OVF  = 3'd4;

endpackage

// File: rtl/rx_byte_assembler.sv
// rtl/rx_byte_assembler.sv - MSB-first bit-to-byte shift register with 3-bit bit counter
// Ports:
//   clk, rst      clock, asynchronous active-low reset
//   clr           synchronous clear of shift register and bit counter (wins over shift_en)
//   shift_en      shift bit_in in this cycle
//   bit_in        serial bit
//   data_next     shift register contents including this cycle's bit
//   done          this cycle's shift completes the 8th bit
module rx_byte_assembler (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       shift_en,
    input  logic       bit_in,
    output logic [7:0] data_next,
    output logic       done
);

    logic [7:0] sreg;
    logic [2:0] cnt;

    // Exposing the post-update value lets the controller compare the sliding
    // window and capture whole bytes in the same cycle the bit arrives.
    assign data_next = {sreg[6:0], bit_in};
    assign done      = shift_en && (cnt == 3'd7);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sreg <= 8'd0;
            cnt  <= 3'd0;
        end else if (clr) begin
            sreg <= 8'd0;
            cnt  <= 3'd0;
        end else if (shift_en) begin
            sreg <= data_next;
            cnt  <= cnt + 3'd1;
        end
    end

endmodule

// File: rtl/rx_frame_ctrl.sv
// rtl/rx_frame_ctrl.sv - serial frame receiver: sync hunt, length, payload, checksum, timeout
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   en                       enable frame hunting; low aborts silently to IDLE
//   rx_en                    enable to the bit receiver
//   bit_in, bit_valid        received bit and its qualifier
//   byte_out, byte_valid     payload byte stream, held until byte_ready
//   byte_ready               downstream accepts byte_out
//   sof, frame_ok, frame_err one-cycle status pulses
//   err_code                 last error code (rx_pkg ERR_*)
module rx_frame_ctrl
    import rx_pkg::*;
#(
    parameter logic [7:0] SYNC_WORD = 8'hD5,
    parameter int         MAX_LEN   = 64,
    parameter int         TIMEOUT   = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    output logic       rx_en,
    input  logic       bit_in,
    input  logic       bit_valid,
    output logic [7:0] byte_out,
    output logic       byte_valid,
    input  logic       byte_ready,
    output logic       sof,
    output logic       frame_ok,
    output logic       frame_err,
    output logic [2:0] err_code
);

    localparam int            TW       = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic [8:0]    LEN_MAX  = 9'(MAX_LEN);

    rx_state_t     state, state_next;
    logic          asm_clr, asm_shift, asm_done;
    logic [7:0]    asm_data;
    logic [7:0]    len_cnt, csum;
    logic [TW-1:0] tmo_cnt;
    logic          in_frame, tmo_hit;
    logic          load_len, push_byte, sof_set, ok_set, err_set;
    logic [2:0]    err_val;

    rx_byte_assembler u_asm (
        .clk       (clk),
        .rst       (rst),
        .clr       (asm_clr),
        .shift_en  (asm_shift),
        .bit_in    (bit_in),
        .data_next (asm_data),
        .done      (asm_done)
    );

    assign in_frame = (state == ST_LEN) || (state == ST_PAYLOAD) || (state == ST_CHECK);
    assign rx_en    = (state == ST_HUNT) || in_frame;
    // Fires on the TIMEOUT-th consecutive cycle without a bit.
    assign tmo_hit  = !bit_valid && (tmo_cnt == TMO_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_next;
    end

    always_comb begin
        state_next = state;
        asm_clr    = 1'b0;
        asm_shift  = 1'b0;
        load_len   = 1'b0;
        push_byte  = 1'b0;
        sof_set    = 1'b0;
        ok_set     = 1'b0;
        err_set    = 1'b0;
        err_val    = ERR_NONE;
        case (state)
            ST_IDLE: begin
                state_next = ST_HUNT;
                asm_clr    = 1'b1;
            end
            ST_HUNT: begin
                asm_shift = bit_valid;
                if (bit_valid && asm_data == SYNC_WORD) begin
                    state_next = ST_LEN;
                    sof_set    = 1'b1;
                    asm_clr    = 1'b1;
                end
            end
            ST_LEN: begin
                asm_shift = bit_valid;
                if (asm_done) begin
                    if (asm_data == 8'd0 || {1'b0, asm_data} > LEN_MAX) begin
                        state_next = ST_ERR;
                        err_set    = 1'b1;
                        err_val    = ERR_LEN;
                    end else begin
                        state_next = ST_PAYLOAD;
                        load_len   = 1'b1;
                    end
                end else if (tmo_hit) begin
                    state_next = ST_ERR;
                    err_set    = 1'b1;
                    err_val    = ERR_TMO;
                end
            end
            ST_PAYLOAD: begin
                asm_shift = bit_valid;
                if (asm_done) begin
                    if (byte_valid && !byte_ready) begin
                        state_next = ST_ERR;
                        err_set    = 1'b1;
                        err_val    = ERR_OVF;
                    end else begin
                        push_byte = 1'b1;
                        if (len_cnt == 8'd1) state_next = ST_CHECK;
                    end
                end else if (tmo_hit) begin
                    state_next = ST_ERR;
                    err_set    = 1'b1;
                    err_val    = ERR_TMO;
                end
            end
            ST_CHECK: begin
                asm_shift = bit_valid;
                if (asm_done) begin
                    if (asm_data == csum) begin
                        state_next = ST_HUNT;
                        ok_set     = 1'b1;
                        asm_clr    = 1'b1;
                    end else begin
                        state_next = ST_ERR;
                        err_set    = 1'b1;
                        err_val    = ERR_CSUM;
                    end
                end else if (tmo_hit) begin
                    state_next = ST_ERR;
                    err_set    = 1'b1;
                    err_val    = ERR_TMO;
                end
            end
            ST_ERR: begin
                state_next = ST_HUNT;
                asm_clr    = 1'b1;
            end
            default: state_next = ST_IDLE;
        endcase
        // Disable overrides everything and aborts without reporting.
        if (!en) begin
            state_next = ST_IDLE;
            asm_clr    = 1'b1;
            asm_shift  = 1'b0;
            load_len   = 1'b0;
            push_byte  = 1'b0;
            sof_set    = 1'b0;
            ok_set     = 1'b0;
            err_set    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            byte_out   <= 8'd0;
            byte_valid <= 1'b0;
            sof        <= 1'b0;
            frame_ok   <= 1'b0;
            frame_err  <= 1'b0;
            err_code   <= ERR_NONE;
            len_cnt    <= 8'd0;
            csum       <= 8'd0;
            tmo_cnt    <= '0;
        end else begin
            sof       <= sof_set;
            frame_ok  <= ok_set;
            frame_err <= err_set;
            if (sof_set)      err_code <= ERR_NONE;
            else if (err_set) err_code <= err_val;

            if (bit_valid || !in_frame) tmo_cnt <= '0;
            else                        tmo_cnt <= tmo_cnt + TW'(1);

            if (load_len) begin
                len_cnt <= asm_data;
                csum    <= 8'd0;
            end
            if (push_byte) begin
                byte_out <= asm_data;
                csum     <= csum + asm_data;
                len_cnt  <= len_cnt - 8'd1;
            end

            // A new byte may replace one accepted in the same cycle; a pending
            // byte survives into CHECK/HUNT but never into ERR or IDLE.
            if (state_next == ST_ERR || state_next == ST_IDLE) byte_valid <= 1'b0;
            else if (push_byte)                                  byte_valid <= 1'b1;
            else if (byte_ready)                                 byte_valid <= 1'b0;
        end
    end

endmodule

// File: doc/rx_frame_ctrl.md
RX_FRAME_CTRL -- requirements
Module: rx_frame_ctrl

Interface
REQ-001 SHALL have parameter SYNC_WORD, default 8'hD5, frame sync byte.
REQ-002 SHALL have parameter MAX_LEN, default 64, maximum payload length in bytes.
REQ-003 SHALL have parameter TIMEOUT, default 1024, idle clock cycles allowed between valid bits inside a frame.
REQ-004 SHALL have port: clk  input  1  single system clock, all logic on rising edge.
REQ-005 SHALL have port: rst  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port: en  input  1  enable frame hunting; low forces IDLE.
REQ-007 SHALL have port: rx_en  output  1  enable to the bit receiver.
REQ-008 SHALL have port: bit_in  input  1  received bit (receiver dout).
REQ-009 SHALL have port: bit_valid  input  1  bit_in qualifier (receiver vout).
REQ-010 SHALL have port: byte_out  output  8  payload byte.
REQ-011 SHALL have port: byte_valid  output  1  byte_out valid.
REQ-012 SHALL have port: byte_ready  input  1  downstream accepts byte_out.
REQ-013 SHALL have port: sof  output  1  one-cycle pulse, sync word matched.
REQ-014 SHALL have port: frame_ok  output  1  one-cycle pulse, frame complete and checksum correct.
REQ-015 SHALL have port: frame_err  output  1  one-cycle pulse, frame aborted with error.
REQ-016 SHALL have port: err_code  output  3  last error: 0 none, 1 LEN, 2 CSUM, 3 TMO, 4 OVF.

Function
REQ-017 SHALL implement states IDLE, HUNT, LEN, PAYLOAD, CHECK, ERR.
REQ-018 SHALL shift bits MSB-first, only on cycles with bit_valid=1.
REQ-019 IDLE: rx_en=0; en=1 -> HUNT next cycle.
REQ-020 HUNT: rx_en=1; 8-bit sliding shift register, after the update equal to SYNC_WORD -> LEN, sof pulse same cycle as the transition, err_code cleared to 0.
REQ-021 LEN: collect 8 bits; length 0 or >MAX_LEN -> ERR code 1; else PAYLOAD with byte counter loaded.
REQ-022 PAYLOAD: each 8th bit completes a byte; byte_valid rises the cycle after that bit_valid, byte_out held stable until byte_valid&&byte_ready.
REQ-023 Checksum SHALL be the 8-bit wraparound sum of payload bytes only, sync and length excluded.
REQ-024 After the last payload byte completes -> CHECK; collect 8 bits; equal to checksum -> frame_ok pulse, HUNT; else ERR code 2.
REQ-025 Byte completing while byte_valid=1 and byte_ready=0 -> ERR code 4; the pending byte is dropped.
REQ-026 In LEN, PAYLOAD, CHECK: counter reset on every bit_valid; reaching TIMEOUT cycles -> ERR code 3.
REQ-027 ERR: frame_err pulse for one cycle, byte_valid cleared, then HUNT if en=1 else IDLE; err_code held until next sof.
REQ-028 en=0 in any state -> IDLE next cycle, silent abort: no frame_err, byte_valid cleared, err_code unchanged.
REQ-029 A pending byte MAY be accepted in the cycle CHECK or HUNT is entered; byte_valid SHALL remain held until it is accepted, except on ERR or abort.
REQ-030 Bits arriving in IDLE or ERR SHALL be ignored; HUNT shift register cleared on entry to HUNT.
REQ-031 sof, frame_ok, frame_err SHALL be mutually exclusive in any cycle.

Reset
REQ-032 rst=0 SHALL asynchronously force IDLE, rx_en=0, byte_out=0, byte_valid=0, sof=0, frame_ok=0, frame_err=0, err_code=0, all counters and shift registers 0.
REQ-033 Reset release SHALL take effect on the next rising clk; rst low mid-frame discards the frame without frame_err.

Structure
REQ-034 State enum and err_code constants SHALL live in a shared package, rx_pkg.
REQ-035 Bit-to-byte assembly (shift register plus 3-bit bit counter) SHALL be one sub-module, rx_byte_assembler; FSM, checksum, timeout and output register stay in rx_frame_ctrl.

Verification
REQ-036 Good frame: D5, len 03, payload 11 22 33, csum 66, byte_ready=1 -> sof once, bytes 11,22,33 in order, frame_ok once, err_code 0.
REQ-037 Bad checksum: D5 03 11 22 33 67 -> three bytes out, frame_err, err_code 2, returns to HUNT.
REQ-038 Length error: D5 00 then D5 41 with MAX_LEN=64 -> frame_err twice, err_code 1 each time.
REQ-039 Timeout: D5 02 AA, then no bit_valid for 1024 cycles -> frame_err, err_code 3.
REQ-040 Backpressure: good frame with byte_ready=0 throughout -> first byte held, second byte completes -> frame_err, err_code 4.
REQ-041 Abort/reset: en=0 mid-payload -> IDLE, no frame_err, byte_valid 0; repeat with rst=0 mid-payload -> all outputs 0 immediately.
